// File: rtl/uart_tx_feeder.sv
// Byte FIFO and present/advance FSM feeding uart_tx so frames go out back-to-back.
// Each byte is held on tx_data_o until uart_tx signals it has taken it.
module uart_tx_feeder #(
    parameter int P_DEPTH = 16,
    parameter int P_LVL_W = $clog2(P_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               wr_valid_i,
    input  logic [7:0]         wr_data_i,
    output logic               wr_ready_o,
    input  logic               flush_i,
    output logic               tx_enable_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    input  logic               tx_data_sent_i,
    output logic [P_LVL_W-1:0] level_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               idle_o
);

    localparam int PTR_W = $clog2(P_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [P_LVL_W-1:0] level_q;
    logic [7:0]         tx_data_q;
    logic               sent_q;
    logic               sent_edge;
    logic               fifo_empty;
    logic               fifo_full;
    logic               do_write;
    logic               do_pop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == P_LVL_W'(P_DEPTH));
    assign wr_ready_o = !fifo_full && !flush_i;
    assign do_write   = wr_valid_i && wr_ready_o;

    // Only the rising edge of data_sent advances, so level or pulse styles both count once.
    assign sent_edge  = tx_data_sent_i && !sent_q;

    always_comb begin
        state_d = state_q;
        do_pop  = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        do_pop  = 1'b1;
                        state_d = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (sent_edge) begin
                        if (!fifo_empty) begin
                            do_pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= tx_data_sent_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_write, do_pop})
                2'b10:   level_q <= level_q + P_LVL_W'(1);
                2'b01:   level_q <= level_q - P_LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array carries no reset; only occupied entries are ever read.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_data_q <= 8'h00;
        end else if (do_pop) begin
            tx_data_q <= mem[rd_ptr_q];
        end
    end

    assign tx_enable_o = (state_q == ST_PRESENT);
    assign tx_data_o   = tx_data_q;
    assign level_o     = level_q;
    assign empty_o     = fifo_empty;
    assign full_o      = fifo_full;
    assign idle_o      = fifo_empty && (state_q == ST_IDLE) && !tx_busy_i;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder driving a small behavioural uart_tx stand-in
// that captures a byte when idle and raises data_sent as a level two cycles later.
module tb_uart_tx_feeder;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int FRAME = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_valid = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_ready;
    logic             flush = 1'b0;
    logic             tx_enable;
    logic [7:0]       tx_data;
    logic             u_busy;
    logic             u_sent;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             idle;

    logic             u_stall = 1'b0;
    int               u_cnt;
    logic [7:0]       rx_q [$];

    int errors = 0;
    int checks = 0;
    int lvl_max = 0;
    int en_falls = 0;
    logic en_prev = 1'b0;

    uart_tx_feeder #(.P_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wr_valid_i     (wr_valid),
        .wr_data_i      (wr_data),
        .wr_ready_o     (wr_ready),
        .flush_i        (flush),
        .tx_enable_o    (tx_enable),
        .tx_data_o      (tx_data),
        .tx_busy_i      (u_busy),
        .tx_data_sent_i (u_sent),
        .level_o        (level),
        .empty_o        (empty),
        .full_o         (full),
        .idle_o         (idle)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: a captured byte is what reaches the line receiver.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_busy <= 1'b0;
            u_sent <= 1'b0;
            u_cnt  <= 0;
        end else if (!u_busy) begin
            u_sent <= 1'b0;
            if (tx_enable && !u_stall) begin
                u_busy <= 1'b1;
                u_cnt  <= 0;
                rx_q.push_back(tx_data);
            end
        end else begin
            u_cnt <= u_cnt + 1;
            if (u_cnt == 1) u_sent <= 1'b1;
            if (u_cnt == FRAME - 1) begin
                u_busy <= 1'b0;
                u_sent <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (int'(level) > lvl_max) lvl_max = int'(level);
        if (en_prev && !tx_enable) en_falls++;
        en_prev = tx_enable;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(idle && !tx_enable && !u_busy) && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (!(idle && !tx_enable && !u_busy)) begin
            errors++;
            $display("FAIL %s_drain: idle=%b enable=%b busy=%b, want idle within 2000 cycles",
                     name, idle, tx_enable, u_busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", tx_enable); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_single();
        int n;
        rx_q.delete();
        wr_valid = 1'b1;
        wr_data  = 8'h48;
        step();
        wr_valid = 1'b0;
        checks++; if (level !== 3'd1 || tx_enable !== 1'b0) begin errors++; $display("FAIL single_accept: level=%0d enable=%b want 1/0", level, tx_enable); end
        step();
        checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", tx_enable); end
        checks++; if (tx_data !== 8'h48) begin errors++; $display("FAIL single_data: got %h want 48", tx_data); end
        n = 0;
        while (!u_sent && n < 100) begin step(); n++; end
        checks++; if (u_sent !== 1'b1) begin errors++; $display("FAIL single_sent_wait: data_sent never rose within 100 cycles"); end
        step();
        checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL single_enable_fall: got %b want 0", tx_enable); end
        wait_drain("single");
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h48) begin errors++; $display("FAIL single_rx_byte: got %h want 48", rx_q[0]); end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [5];
        exp = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        rx_q.delete();
        lvl_max = 0;
        en_falls = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = exp[i];
            step();
        end
        wr_valid = 1'b0;
        wait_drain("burst");
        checks++; if (lvl_max != 4) begin errors++; $display("FAIL burst_level_peak: got %0d want 4", lvl_max); end
        checks++; if (en_falls != 1) begin errors++; $display("FAIL burst_enable_falls: got %0d want 1", en_falls); end
        checks++; if (empty !== 1'b1 || tx_enable !== 1'b0) begin errors++; $display("FAIL burst_end: empty=%b enable=%b want 1/0", empty, tx_enable); end
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL burst_rx_count: got %0d want 5", rx_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL burst_rx_%0d: got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_full();
        int n;
        rx_q.delete();
        u_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            step();
        end
        wr_data = 8'h06;
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_state: level=%0d full=%b want 4/1", level, full); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        step();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold: level=%0d want 4", level); end
        u_stall = 1'b0;
        n = 0;
        while (level != 3'd3 && n < 100) begin step(); n++; end
        checks++; if (wr_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL full_after_pop: wr_ready=%b full=%b want 1/0", wr_ready, full); end
        step();
        wr_valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_accept06: level=%0d want 4", level); end
        wait_drain("full");
        checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL full_rx_count: got %0d want 6", rx_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL full_rx_%0d: got %h want %h", i, rx_q[i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        int gap;
        rx_q.delete();
        lvl_max = 0;
        for (int i = 0; i < 20; i++) begin
            gap = int'($urandom_range(3, 0));
            repeat (gap) step();
            wr_valid = 1'b1;
            wr_data  = 8'hA0 + 8'(i);
            n = 0;
            while (!wr_ready && n < 200) begin step(); n++; end
            step();
            wr_valid = 1'b0;
        end
        wait_drain("wrap");
        checks++; if (lvl_max > 4) begin errors++; $display("FAIL wrap_level_max: got %0d want <=4", lvl_max); end
        checks++; if (rx_q.size() != 20) begin errors++; $display("FAIL wrap_rx_count: got %0d want 20", rx_q.size()); end
        else begin
            for (int i = 0; i < 20; i++) begin
                checks++; if (rx_q[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wrap_rx_%0d: got %h want %h", i, rx_q[i], 8'hA0 + 8'(i)); end
            end
        end
    endtask

    task automatic test_flush();
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
            step();
        end
        checks++; if (u_busy !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL flush_pre: busy=%b level=%0d want 1/3", u_busy, level); end
        flush   = 1'b1;
        wr_data = 8'h99;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wr_ready: got %b want 0", wr_ready); end
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        checks++; if (level !== '0 || tx_enable !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL flush_cleared: level=%0d enable=%b empty=%b want 0/0/1", level, tx_enable, empty); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b want 0", idle); end
        wait_drain("flush");
        checks++; if (level !== '0) begin errors++; $display("FAIL flush_write_refused: level=%0d want 0", level); end
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL flush_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h10) begin errors++; $display("FAIL flush_rx_byte: got %h want 10", rx_q[0]); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h21 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        n = 0;
        while (rx_q.size() < 2 && n < 200) begin step(); n++; end
        checks++; if (tx_enable !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL areset_pre: enable=%b level=%0d want 1/1", tx_enable, level); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx_enable !== 1'b0 || level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL areset_immediate: enable=%b level=%0d empty=%b want 0/0/1", tx_enable, level, empty); end
        step();
        #2 rst_n = 1'b1;
        step();
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        step();
        wr_valid = 1'b0;
        wait_drain("areset");
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL areset_rx_count: got %0d want 3", rx_q.size()); end
        else begin
            checks++; if (rx_q[2] !== 8'h5A) begin errors++; $display("FAIL areset_rx_byte: got %h want 5A", rx_q[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within 400000 time units");
        $fatal(1);
    end

endmodule
